div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative RV32M divider for DIV/DIVU/REM/REMU.
- Sits directly downstream of the register-file read ports: it takes rdata1 (dividend) and rdata2 (divisor) in the execute stage.
- Its result goes straight back to the register-file write port (wren/waddr/wdata) through the writeback mux.
- Single outstanding operation. Restoring radix-2 algorithm, one quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN+1.

Ports:
- rst  input  1  asynchronous active-low reset
- clk  input  1  clock, all state on rising edge
- div_valid  input  1  request strobe from execute
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rdata1  input  32  dividend from register file read port 1
- rdata2  input  32  divisor from register file read port 2
- rd_addr  input  5  destination register
- flush  input  1  pipeline kill; aborts any operation
- div_ready  output  1  unit can accept a request this cycle
- wren  output  1  write strobe to register file
- waddr  output  5  write address to register file
- wdata  output  32  quotient or remainder

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, div_ready=1, wren=0, waddr=0, wdata=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- div_ready=1 only in IDLE. Accept occurs when div_valid && div_ready && !flush.
- IDLE, on accept:
  - Latch op, rd_addr.
  - Signed ops (DIV/REM): latch |rdata1|, |rdata2|, quotient sign = sign1^sign2, remainder sign = sign1. Unsigned ops: latch raw operands.
  - Latch div_zero = (rdata2==0).
  - Latch ovf = signed && rdata1==0x80000000 && rdata2==0xFFFFFFFF.
  - Clear partial remainder (33 bits), counter = XLEN. Go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor (33-bit). If trial is non-negative, rem=trial and quotient LSB=1; else quotient LSB=0.
  - Decrement counter. When it reaches 0 after the 32nd iteration, go to FIX.
- FIX (one cycle): select the result.
  - div_zero: quotient=0xFFFFFFFF; remainder=original rdata1.
  - ovf: quotient=0x80000000; remainder=0.
  - Otherwise: negate quotient if its sign flag is set; negate remainder if its sign flag is set.
  - DIV/DIVU select quotient; REM/REMU select remainder.
  - Register the result into wdata, waddr=latched rd. Go to DONE.
- DONE:
  - wren = (waddr!=0) for exactly this one cycle; wdata/waddr valid.
  - Next cycle go to IDLE. wren returns to 0; wdata/waddr hold their last value.
- Latency: accept at cycle T -> CALC T+1..T+32 -> FIX T+33 -> wren at T+34. The next request can be accepted at T+35.
- flush:
  - In any state, next state=IDLE with no wren. A flush in DONE suppresses wren that cycle (combinational gate).
  - flush together with div_valid in IDLE: request is not accepted.
- Inputs are ignored while div_ready=0; the requester holds div_valid until it sees div_ready.
- Asynchronous reset mid-operation returns to IDLE immediately; the result is lost, wren=0.
- Writes to x0 never assert wren.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if div_zero, ovf, or unsigned magnitude |dividend| < |divisor| at accept, skip CALC. Go directly to FIX, with rem = magnitude dividend and quo = 0 in the last case; wren occurs at T+2.
- Undefined: every operation takes the full T+34 latency. Results are bit-identical in both builds.

Test Plan:
- DIV rdata1=0xFFFFFFF9 (-7), rdata2=2, rd=5 -> single wren at T+34, waddr=5, wdata=0xFFFFFFFD (-3). Same operands with REM -> wdata=0xFFFFFFFF (-1).
- DIVU 100/7 -> wdata=14. REMU 100/7 -> wdata=2. DIVU 0xFFFFFFFF/1 -> wdata=0xFFFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Assert flush at T+10, then issue DIVU 9/3 at T+12 -> no wren for the first op; second op gives wren at T+46 with wdata=3. div_valid held while busy is not accepted.
- DIV 10/3 with rd=0 -> wren stays 0 throughout. Assert rst=0 at T+20 -> outputs at reset values immediately, div_ready=1.
- DIV_EARLY_EXIT_EN builds: DIVU 3/10 -> wren at T+2, wdata=0. REMU 3/10 -> wdata=3. DIV 5/0 -> wren at T+2, wdata=0xFFFFFFFF.

Source files
------------

// File: rtl/div_unit_if.sv
// Execute-side request and register-file write-port bundle for div_unit.
interface div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            div_valid;
  logic [1:0]      div_op;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [4:0]      rd_addr;
  logic            flush;
  logic            div_ready;
  logic            wren;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;

  modport master (
    output div_valid, div_op, rdata1, rdata2, rd_addr, flush,
    input  div_ready, wren, waddr, wdata
  );

  modport slave (
    input  div_valid, div_op, rdata1, rdata2, rd_addr, flush,
    output div_ready, wren, waddr, wdata
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 RV32M divider (DIV/DIVU/REM/REMU), single outstanding op.
// Optional macro DIV_EARLY_EXIT_EN: skip iterations for div-by-zero, overflow and |a|<|b|.
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned   RW      = XLEN + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state, state_nxt;
  logic             ready;
  logic             op_rem;
  logic [4:0]       rd;
  logic             sign_q, sign_r, div_zero, ovf;
  logic [XLEN-1:0]  dividend, divisor, quo;
  logic [RW-1:0]    rem;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       waddr;
  logic [XLEN-1:0]  wdata;

  logic             accept, is_signed, a_neg, b_neg, zero_in, ovf_in, early;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [RW-1:0]    rem_sh, trial;
  logic [XLEN-1:0]  q_res, r_res, result;

  // Request decode: operand magnitudes and special cases
  always_comb begin
    accept    = bus.div_valid && ready && !bus.flush;
    is_signed = !bus.div_op[0];
    a_neg     = is_signed && bus.rdata1[XLEN-1];
    b_neg     = is_signed && bus.rdata2[XLEN-1];
    a_mag     = a_neg ? -bus.rdata1 : bus.rdata1;
    b_mag     = b_neg ? -bus.rdata2 : bus.rdata2;
    zero_in   = (bus.rdata2 == '0);
    ovf_in    = is_signed && (bus.rdata1 == INT_MIN) && (bus.rdata2 == '1);
`ifdef DIV_EARLY_EXIT_EN
    early     = zero_in || ovf_in || (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
  end

  // One restoring step plus final sign/special-case selection
  always_comb begin
    rem_sh = RW'({rem, quo[XLEN-1]});
    trial  = rem_sh - {1'b0, divisor};
    if (div_zero) begin
      q_res = '1;
      r_res = dividend;
    end else if (ovf) begin
      q_res = INT_MIN;
      r_res = '0;
    end else begin
      q_res = sign_q ? -quo : quo;
      r_res = sign_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end
    result = op_rem ? r_res : q_res;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = early ? S_FIX : S_CALC;
      S_CALC:  if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ready <= 1'b1;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_rem   <= 1'b0;
      rd       <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_rem   <= bus.div_op[1];
          rd       <= bus.rd_addr;
          sign_q   <= a_neg ^ b_neg;
          sign_r   <= a_neg;
          div_zero <= zero_in;
          ovf      <= ovf_in;
          dividend <= bus.rdata1;
          divisor  <= b_mag;
          cnt      <= CNT_W'(XLEN);
          // Early exit leaves the dividend as the remainder with a zero quotient
          if (early) begin
            rem <= {1'b0, a_mag};
            quo <= '0;
          end else begin
            rem <= '0;
            quo <= a_mag;
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (!trial[XLEN]) begin
            rem <= trial;
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: if (!bus.flush) begin
          wdata <= result;
          waddr <= rd;
        end
        default: ;
      endcase
    end
  end

  // Flush gates the write strobe combinationally so a late kill still blocks it
  assign bus.div_ready = ready;
  assign bus.wren      = (state == S_DONE) && (waddr != '0) && !bus.flush;
  assign bus.waddr     = waddr;
  assign bus.wdata     = wdata;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, flush/reset sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32)) bus ();
  div_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic [31:0] exp, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic longint to_num(input logic [1:0] op, input logic [31:0] x);
    if (op[0]) return longint'({32'b0, x});
    return longint'($signed(x));
  endfunction

  function automatic longint abs_num(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint sa, sb;
    sa = to_num(op, a);
    sb = to_num(op, b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit skip;
    skip = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (abs_num(to_num(op, a)) < abs_num(to_num(op, b)));
    return (EARLY && skip) ? 2 : 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.div_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: div_ready stayed 0 for 60 cycles, required 1");
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.div_valid = 1'b1;
    bus.div_op    = op;
    bus.rdata1    = a;
    bus.rdata2    = b;
    bus.rd_addr   = rd;
  endtask

  // Issue one op and watch the write port until well past the expected writeback
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input string name);
    int lat, nw, first;
    logic [4:0] wa;
    lat = ref_lat(op, a, b);
    nw = 0; first = 0; wa = '0;
    wait_ready();
    drive(op, a, b, rd);
    for (int i = 1; i <= lat + 6; i++) begin
      @(negedge clk);
      if (i == 1) bus.div_valid = 1'b0;
      if (bus.wren) begin
        nw++;
        if (first == 0) first = i;
        wa = bus.waddr;
      end
    end
    check({name, "_wren_count"}, 32'(nw), (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      check({name, "_latency"}, 32'(first), 32'(lat));
      check({name, "_waddr"}, {27'b0, wa}, {27'b0, rd});
    end
    check({name, "_wdata"}, bus.wdata, expv);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          sel, nw, first, lat;
    logic [31:0] wd;

    bus.div_valid = 1'b0; bus.div_op = 2'b00; bus.rdata1 = '0; bus.rdata2 = '0;
    bus.rd_addr = '0; bus.flush = 1'b0;
    rst = 1'b0;

    add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, "div_m7_2");
    add_vec(OP_REM,  32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFF, "rem_m7_2");
    add_vec(OP_DIVU, 32'd100,       32'd7,          5'd1,  32'd14,        "divu_100_7");
    add_vec(OP_REMU, 32'd100,       32'd7,          5'd2,  32'd2,         "remu_100_7");
    add_vec(OP_DIVU, 32'hFFFF_FFFF, 32'd1,          5'd31, 32'hFFFF_FFFF, "divu_max_1");
    add_vec(OP_DIV,  32'd5,         32'd0,          5'd8,  32'hFFFF_FFFF, "div_5_0");
    add_vec(OP_REM,  32'd5,         32'd0,          5'd9,  32'd5,         "rem_5_0");
    add_vec(OP_REM,  32'hFFFF_FFF9, 32'd0,          5'd9,  32'hFFFF_FFF9, "rem_m7_0");
    add_vec(OP_REMU, 32'h1234_5678, 32'd0,          5'd10, 32'h1234_5678, "remu_x_0");
    add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  5'd11, 32'h8000_0000, "div_ovf");
    add_vec(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  5'd12, 32'd0,         "rem_ovf");
    add_vec(OP_DIVU, 32'd3,         32'd10,         5'd13, 32'd0,         "divu_3_10");
    add_vec(OP_REMU, 32'd3,         32'd10,         5'd14, 32'd3,         "remu_3_10");
    add_vec(OP_DIV,  32'd7,         32'hFFFF_FFFE,  5'd15, 32'hFFFF_FFFD, "div_7_m2");
    add_vec(OP_REM,  32'd7,         32'hFFFF_FFFE,  5'd16, 32'd1,         "rem_7_m2");
    add_vec(OP_DIV,  32'd10,        32'd3,          5'd0,  32'd3,         "div_rd0");

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, bus.div_ready}, 32'd1);
    check("reset_wren",  {31'b0, bus.wren},      32'd0);
    check("reset_waddr", {27'b0, bus.waddr},     32'd0);
    check("reset_wdata", bus.wdata,              32'd0);
    rst = 1'b1;

    foreach (vecs[k]) run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].rd, vecs[k].exp, vecs[k].name);

    // Flush mid-calculation, valid held while busy, then a fresh op
    wait_ready();
    drive(OP_DIVU, 32'd1000, 32'd7, 5'd3);
    lat = 12 + ref_lat(OP_DIVU, 32'd9, 32'd3);
    nw = 0; first = 0; wd = '0;
    for (int i = 1; i <= 52; i++) begin
      @(negedge clk);
      if (bus.wren) begin
        nw++;
        if (first == 0) first = i;
        wd = bus.wdata;
      end
      if (i == 5) check("busy_ready", {31'b0, bus.div_ready}, 32'd0);
      if (i == 9) bus.div_valid = 1'b0;
      if (i == 10) bus.flush = 1'b1;
      if (i == 11) begin
        bus.flush = 1'b0;
        check("flush_ready", {31'b0, bus.div_ready}, 32'd1);
      end
      if (i == 12) drive(OP_DIVU, 32'd9, 32'd3, 5'd6);
      if (i == 13) bus.div_valid = 1'b0;
    end
    check("flush_wren_count", 32'(nw), 32'd1);
    check("flush_second_latency", 32'(first), 32'(lat));
    check("flush_second_wdata", wd, 32'd3);

    // Flush together with valid in IDLE: no accept
    wait_ready();
    drive(OP_DIVU, 32'd100, 32'd7, 5'd9);
    bus.flush = 1'b1;
    @(negedge clk);
    check("idle_flush_ready", {31'b0, bus.div_ready}, 32'd1);
    bus.div_valid = 1'b0;
    bus.flush = 1'b0;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wren) nw++;
    end
    check("idle_flush_no_wren", 32'(nw), 32'd0);

    // Flush during writeback cycle blocks the strobe immediately
    wait_ready();
    drive(OP_DIVU, 32'd100, 32'd7, 5'd4);
    lat = ref_lat(OP_DIVU, 32'd100, 32'd7);
    nw = 0;
    for (int i = 1; i <= lat + 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.div_valid = 1'b0;
      if (i == lat) begin
        check("done_wren_pre_flush", {31'b0, bus.wren}, 32'd1);
        bus.flush = 1'b1;
        #1;
        check("done_flush_wren", {31'b0, bus.wren}, 32'd0);
      end else if (bus.wren) begin
        nw++;
      end
      if (i == lat + 1) bus.flush = 1'b0;
    end
    check("done_flush_no_other_wren", 32'(nw), 32'd0);

    // Asynchronous reset mid-operation
    wait_ready();
    drive(OP_DIV, 32'd10, 32'd3, 5'd7);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.div_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'b0, bus.div_ready}, 32'd1);
    check("midrst_wren",  {31'b0, bus.wren},      32'd0);
    check("midrst_waddr", {27'b0, bus.waddr},     32'd0);
    check("midrst_wdata", bus.wdata,              32'd0);
    @(negedge clk);
    rst = 1'b1;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wren) nw++;
    end
    check("midrst_no_wren", 32'(nw), 32'd0);

    // Randomized ops against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = 32'($urandom_range(1, 15));
      if (sel == 2) a = 32'($urandom_range(0, 50));
      if (sel == 3) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(op, a, b, rd, ref_res(op, a, b), $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
